// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice (two half adders) processes one bit per cycle,
// with valid/ready handshakes on operand intake and result delivery.

module half_adder (
    output logic S,
    output logic C,
    input  logic x,
    input  logic y
);
    assign S = x ^ y;
    assign C = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_a, shift_b, sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s0, c0, s1, c1;
    logic             bit_sum, bit_carry, last_bit;

    half_adder u_ha0 (.S(s0), .C(c0), .x(shift_a[0]), .y(shift_b[0]));
    half_adder u_ha1 (.S(s1), .C(c1), .x(s0),         .y(carry));

    assign bit_sum   = s1;
    assign bit_carry = c0 | c1;
    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // in_ready is also gated by reset so it stays low while reset is held
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !reset;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_a <= '0;
            shift_b <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_a <= a;
                        shift_b <= b;
                        carry   <= cin;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    shift_a <= {1'b0, shift_a[WIDTH-1:1]};
                    shift_b <= {1'b0, shift_b[WIDTH-1:1]};
                    sum_sr  <= {bit_sum, sum_sr[WIDTH-1:1]};
                    carry   <= bit_carry;
                    // counter wraps to 0 on the last bit so it never reaches WIDTH
                    if (last_bit) begin
                        cnt  <= '0;
                        sum  <= {bit_sum, sum_sr[WIDTH-1:1]};
                        cout <= bit_carry;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder: WIDTH=8 instance for protocol and arithmetic,
// WIDTH=4 instance swept over every operand combination.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       reset;

    logic       iv8, ir8, cin8, ov8, or8, cout8, busy8;
    logic [7:0] a8, b8, sum8;
    logic       iv4, ir4, cin4, ov4, or4, cout4, busy4;
    logic [3:0] a4, b4, sum4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full transaction on the 8-bit DUT with latency and hand-off checks
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input string tag);
        int         lat;
        logic [8:0] exp;
        exp = 9'(ta) + 9'(tb_) + 9'(tc);
        @(negedge clk);
        a8 = ta; b8 = tb_; cin8 = tc; iv8 = 1'b1; or8 = 1'b0;
        lat = 0;
        while (!ir8 && lat < 40) begin @(negedge clk); lat++; end
        check({tag, "_ready"}, 64'(ir8), 64'd1);
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 0;
        while (!ov8 && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
        check({tag, "_latency"}, 64'(lat), 64'd8);
        check({tag, "_sum"}, 64'(sum8), 64'(exp[7:0]));
        check({tag, "_cout"}, 64'(cout8), 64'(exp[8]));
        check({tag, "_ready_in_done"}, 64'(ir8), 64'd0);
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0;
        check({tag, "_ov_drop"}, 64'(ov8), 64'd0);
        check({tag, "_ready_back"}, 64'(ir8), 64'd1);
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
        int         lat;
        logic [4:0] exp;
        exp = 5'(ta) + 5'(tb_) + 5'(tc);
        @(negedge clk);
        a4 = ta; b4 = tb_; cin4 = tc; iv4 = 1'b1; or4 = 1'b1;
        lat = 0;
        while (!ir4 && lat < 20) begin @(negedge clk); lat++; end
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
        check($sformatf("w4_%0h_%0h_%0h", ta, tb_, tc), 64'({ov4, cout4, sum4}), 64'({1'b1, exp}));
        @(posedge clk);
    endtask

    initial begin
        logic [7:0] hold_sum;
        logic       hold_cout;
        logic [8:0] exp_q[$];
        logic [8:0] e;
        int         acc_cyc[2];
        int         accepts, results;
        logic       acc;

        reset = 1'b1;
        iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; or8 = 0;
        iv4 = 0; a4 = 0; b4 = 0; cin4 = 0; or4 = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(ir8), 64'd0);
        check("rst_out_valid", 64'(ov8), 64'd0);
        check("rst_sum", 64'(sum8), 64'd0);
        check("rst_cout", 64'(cout8), 64'd0);
        check("rst_busy", 64'(busy8), 64'd0);
        reset = 1'b0;
        #1 check("rel_in_ready", 64'(ir8), 64'd1);

        run8(8'h00, 8'h00, 1'b0, "zero");
        run8(8'hFF, 8'h01, 1'b0, "ff_01");
        run8(8'hA5, 8'h5A, 1'b1, "a5_5a");
        run8(8'h3C, 8'h42, 1'b0, "3c_42");
        for (int i = 0; i < 16; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i));

        // Backpressure: result held while out_ready is low and in_valid stays high
        @(negedge clk);
        a8 = 8'h9C; b8 = 8'h77; cin8 = 1'b1; iv8 = 1'b1; or8 = 1'b0;
        for (int t = 0; t < 30 && !ov8; t++) @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
        hold_sum = sum8; hold_cout = cout8;
        check("bp_sum", 64'({cout8, sum8}), 64'(9'h09C + 9'h077 + 9'd1));
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("bp_hold_sum", 64'(sum8), 64'(hold_sum));
            check("bp_hold_cout", 64'(cout8), 64'(hold_cout));
            check("bp_no_accept", 64'({ov8, ir8}), 64'b10);
        end
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0; or8 = 1'b0;
        check("bp_release", 64'({ov8, ir8}), 64'b01);

        // Reset four edges into an operation
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk) iv8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        check("mid_rst_ov", 64'(ov8), 64'd0);
        check("mid_rst_busy", 64'(busy8), 64'd0);
        check("mid_rst_sum", 64'(sum8), 64'd0);
        @(negedge clk) reset = 1'b0;
        #1 check("mid_rst_ready", 64'(ir8), 64'd1);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            check("mid_rst_no_ov", 64'(ov8), 64'd0);
        end

        // Back-to-back with in_valid and out_ready held high
        @(negedge clk);
        a8 = 8'hC8; b8 = 8'h4B; cin8 = 1'b1; iv8 = 1'b1; or8 = 1'b1;
        accepts = 0; results = 0;
        for (int t = 0; t < 60 && results < 2; t++) begin
            acc = ir8 && iv8;
            if (acc) begin
                exp_q.push_back(9'(a8) + 9'(b8) + 9'(cin8));
                acc_cyc[accepts] = cyc;
                accepts++;
            end
            if (ov8) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                check($sformatf("b2b_res%0d", results), 64'({cout8, sum8}), 64'(e));
                results++;
            end
            @(negedge clk);
            if (acc && accepts == 1) begin a8 = 8'h7F; b8 = 8'h80; cin8 = 1'b1; end
            if (accepts == 2) iv8 = 1'b0;
        end
        check("b2b_results", 64'(results), 64'd2);
        check("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd10);
        iv8 = 1'b0; or8 = 1'b0;

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    run4(4'(x), 4'(y), 1'(c));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
